carryskip_sub_serial: RTL
=========================

Name: carryskip_sub_serial

Overview:
- Digit-serial two's-complement subtractor: computes d = a - b - bin over WIDTH/DIGIT clock cycles, one DIGIT-bit slice per cycle, LSB first.
- Each slice is a DIGIT-bit carry-skip stage fed with ~b, so subtraction runs as a + ~b + ~bin.
- Sits beside the combinational carry-skip adders as the low-area, multi-cycle, handshaked subtract path for datapaths that tolerate latency.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a positive multiple of DIGIT.
- DIGIT, 4, bits processed per cycle (width of one carry-skip slice).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and bin presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow in
- out_valid  output  1  result registers hold a completed result
- out_ready  input  1  consumer accepts result
- d  output  WIDTH  difference a - b - bin, modulo 2^WIDTH
- bout  output  1  borrow out: 1 iff the unsigned result a - b - bin is negative
- ovf  output  1  signed overflow of the two's-complement subtraction

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, d=0, bout=0, ovf=0, digit counter=0, carry=0.
- Reset has priority over every other event. Asserting rst in RUN or DONE aborts the operation: no out_valid pulse, and d/bout/ovf clear.
- States:
  - IDLE: in_ready=1.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE -> RUN on an edge with in_valid=1. That edge does the following:
  - latches a into the operand shift register and ~b into the subtrahend shift register;
  - sets carry=~bin;
  - sets counter=0;
  - captures sign bits a[WIDTH-1] and b[WIDTH-1] for ovf.
- RUN, each edge:
  - takes the low DIGIT bits of both shift registers plus carry through one carry-skip slice;
  - shifts the DIGIT-bit sum into d from the MSB end (d shifts right by DIGIT);
  - shifts the operand registers right by DIGIT;
  - updates carry from the slice carry out;
  - increments counter.
- RUN -> DONE on the edge where counter==WIDTH/DIGIT-1, i.e. after exactly N=WIDTH/DIGIT RUN edges.
- Latency: out_valid is first high in the cycle following the Nth edge after the accept edge.
- On the RUN -> DONE edge:
  - bout=~final_carry;
  - ovf=(a_sign!=b_sign)&&(d_msb!=a_sign), where d_msb is the final result's MSB.
- DONE: d, bout and ovf are held stable while out_valid=1 and out_ready=0, for any number of cycles.
- DONE -> IDLE on an edge with out_ready=1. d/bout/ovf keep their values after out_valid drops.
- No new operand accept in the DONE cycle. Back-to-back throughput is one result per N+2 cycles with out_ready held 1.
- in_valid is ignored outside IDLE. a, b and bin are sampled only on the accept edge.
- Slice arithmetic, for propagate p_i=a_i^~b_i:
  - sum_i = p_i ^ c_i;
  - ripple carry c_{i+1} = (a_i & ~b_i) | (p_i & c_i);
  - slice carry out = (&p) ? carry_in : ripple carry out.
  - The skip path must be functionally identical to the ripple result.
- Degenerate case WIDTH==DIGIT: N=1, single RUN cycle.

Decomposition:
- Shared package carryskip_pkg:
  - DIGIT default constant;
  - state enum {IDLE, RUN, DONE};
  - elaboration check function asserting WIDTH%DIGIT==0 and WIDTH>0.
- One sub-module sub_skip_digit: a combinational DIGIT-wide carry-skip slice.
  - Inputs: x[DIGIT], y[DIGIT], ci.
  - Outputs: s[DIGIT], co, pall.
  - Instantiated once; the top holds only state, counter and shift registers.

Test Plan (WIDTH=8, DIGIT=4 unless noted):
- a=0x05, b=0x03, bin=0 -> d=0x02, bout=0, ovf=0; out_valid rises exactly 2 cycles after the accept edge.
- a=0x03, b=0x05, bin=0 -> d=0xFE, bout=1, ovf=0.
- a=0x80, b=0x01, bin=0 -> d=0x7F, bout=0, ovf=1. Also a=0x7F, b=0xFF, bin=0 -> d=0x80, bout=1, ovf=1.
- Skip path: a=0x00, b=0x00, bin=1 -> all slices full-propagate, d=0xFF, bout=1, ovf=0. Also a=0x5A, b=0x5A, bin=0 -> d=0x00, bout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, d/bout/ovf unchanged, in_ready=0, and in_valid pulses are ignored. Then out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-RUN: assert rst on the first RUN edge -> next cycle IDLE, in_ready=1, out_valid=0, d=0. A fresh a=0xFF, b=0x01 then yields d=0xFE, bout=0. Repeat the 0x05-0x03 case with WIDTH=32, DIGIT=4 and check N=8 cycles of latency.

Source files
------------

// File: rtl/carryskip_pkg.sv
// Shared definitions for the carry-skip subtractor family: default digit size,
// controller states and the operand-geometry sanity check.
package carryskip_pkg;

  localparam int DIGIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when a WIDTH-bit operand splits into a whole number of DIGIT-bit slices.
  function automatic bit width_ok(input int width, input int digit);
    return (width > 0) && (digit > 0) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/sub_skip_digit.sv
// One DIGIT-wide carry-skip slice. The caller feeds the inverted subtrahend on y,
// so x + y + ci realises one digit of a - b with ci acting as the inverted borrow.
module sub_skip_digit
  import carryskip_pkg::*;
#(
  parameter int DIGIT = DIGIT_DEFAULT
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             pall
);

  logic [DIGIT-1:0] p;
  logic [DIGIT:0]   c;

  // Ripple chain across the slice: per-bit propagate, sum and generate/propagate carry.
  always_comb begin
    p    = x ^ y;
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = p[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (p[i] & c[i]);
    end
  end

  // When every bit propagates the incoming carry bypasses the chain unchanged,
  // which is exactly what the ripple would have produced anyway.
  assign pall = &p;
  assign co   = pall ? ci : c[DIGIT];

endmodule

// File: rtl/carryskip_sub_serial.sv
// Digit-serial two's-complement subtractor: d = a - b - bin, one DIGIT-bit slice per
// clock LSB first, with a valid/ready handshake on both operands and result.
module carryskip_sub_serial
  import carryskip_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = DIGIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int             N    = WIDTH / DIGIT;
  localparam int             CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  generate
    if (!width_ok(WIDTH, DIGIT)) begin : g_bad_geometry
      $error("carryskip_sub_serial: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  state_t           state, next_state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             a_sign, b_sign;
  logic [DIGIT-1:0] slice_s;
  logic             slice_co, slice_pall;
  logic             carry_next;
  logic [WIDTH-1:0] d_next;
  logic             accept, last_digit;

  sub_skip_digit #(.DIGIT(DIGIT)) u_slice (
    .x    (a_sh[DIGIT-1:0]),
    .y    (b_sh[DIGIT-1:0]),
    .ci   (carry),
    .s    (slice_s),
    .co   (slice_co),
    .pall (slice_pall)
  );

  assign accept     = (state == IDLE) && in_valid;
  assign last_digit = (state == RUN) && (cnt == LAST);
  assign carry_next = slice_pall ? carry : slice_co;
  assign d_next     = WIDTH'({slice_s, d} >> DIGIT);

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and handshake outputs: accept only when idle, present only when done.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        if (cnt == LAST) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: load operands on accept, consume one slice per RUN edge, finalise flags on the last slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      d      <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= ~b;
      carry  <= ~bin;
      cnt    <= '0;
      a_sign <= a[WIDTH-1];
      b_sign <= b[WIDTH-1];
    end else if (state == RUN) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      d     <= d_next;
      carry <= carry_next;
      cnt   <= cnt + CW'(1);
      if (last_digit) begin
        bout <= ~carry_next;
        ovf  <= (a_sign != b_sign) && (slice_s[DIGIT-1] != a_sign);
      end
    end
  end

endmodule
